minterm_scanner: RTL and testbench

MINTERM_SCANNER -- requirements
Module: minterm_scanner

---
 rtl/minterm_if.sv | 27 ++
 rtl/minterm_scanner.sv | 146 ++++++++++++++
 tb/tb_minterm_scanner.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/minterm_if.sv
// Handshake and data bundle between a minterm scanner and the stimulus/evaluator side.
// "expect" is a reserved word, so the expected truth table is carried as "expected".
interface minterm_if;
  logic        start;
  logic        abort;
  logic [3:0]  lo;
  logic [3:0]  hi;
  logic [15:0] expected;
  logic [3:0]  fn_i;
  logic        fn_f;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] map;
  logic [4:0]  count;
  logic        mismatch;

  modport master (
    output start, abort, lo, hi, expected, fn_f,
    input  fn_i, busy, done, err, map, count, mismatch
  );

  modport slave (
    input  start, abort, lo, hi, expected, fn_f,
    output fn_i, busy, done, err, map, count, mismatch
  );
endinterface

// File: rtl/minterm_scanner.sv
// Walks minterm indices lo..hi through an external 4-input evaluator and captures its truth table,
// counting ones and comparing the captured range against an expected table.
module minterm_scanner #(
  parameter int unsigned SETTLE = 0
) (
  input logic      clk,
  input logic      rst,
  minterm_if.slave bus
);

  // state      | meaning
  // ST_IDLE    | waiting for start; results held
  // ST_SETTLE  | fn_i held while the evaluator settles
  // ST_SAMPLE  | fn_f captured into map/count
  // ST_DONE    | one-cycle done pulse
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam bit          HAS_SETTLE = (SETTLE != 0);
  localparam int unsigned SETTLE_M1  = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam logic [2:0]  SETTLE_LD  = 3'(SETTLE_M1);

  state_t      state;
  logic [3:0]  fn_i_q;
  logic [3:0]  lo_q;
  logic [3:0]  hi_q;
  logic [15:0] exp_q;
  logic [15:0] map_q;
  logic [4:0]  count_q;
  logic [2:0]  settle_cnt;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic        mism_q;

  logic [15:0] map_next;
  logic [15:0] range_mask;
  logic [4:0]  count_next;

  always_comb begin
    map_next           = map_q;
    map_next[fn_i_q]   = bus.fn_f;
    count_next         = count_q + {4'd0, bus.fn_f};
    range_mask         = '0;
    for (int k = 0; k < 16; k++) begin
      if ((4'(k) >= lo_q) && (4'(k) <= hi_q)) range_mask[k] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      fn_i_q     <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      exp_q      <= '0;
      map_q      <= '0;
      count_q    <= '0;
      settle_cnt <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mism_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          // start has priority over abort here; abort only matters mid-scan
          if (bus.start) begin
            if (bus.lo <= bus.hi) begin
              lo_q       <= bus.lo;
              hi_q       <= bus.hi;
              exp_q      <= bus.expected;
              map_q      <= '0;
              count_q    <= '0;
              mism_q     <= 1'b0;
              err_q      <= 1'b0;
              fn_i_q     <= bus.lo;
              settle_cnt <= SETTLE_LD;
              busy_q     <= 1'b1;
              state      <= HAS_SETTLE ? ST_SETTLE : ST_SAMPLE;
            end else begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
              state  <= ST_DONE;
            end
          end
        end

        ST_SETTLE: begin
          if (bus.abort) begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else if (settle_cnt == 3'd0) begin
            state <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 3'd1;
          end
        end

        ST_SAMPLE: begin
          if (bus.abort) begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            map_q   <= map_next;
            count_q <= count_next;
            // hi is checked before incrementing so fn_i never wraps past 15
            if (fn_i_q == hi_q) begin
              mism_q <= |((map_next ^ exp_q) & range_mask);
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= ST_DONE;
            end else begin
              fn_i_q     <= fn_i_q + 4'd1;
              settle_cnt <= SETTLE_LD;
              state      <= HAS_SETTLE ? ST_SETTLE : ST_SAMPLE;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.fn_i     = fn_i_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.map      = map_q;
  assign bus.count    = count_q;
  assign bus.mismatch = mism_q;

endmodule

// File: tb/tb_minterm_scanner.sv
// Directed bench for minterm_scanner: one instance with no settle delay, one with SETTLE=2.
module tb_minterm_scanner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc;

  logic [15:0] eval_tt = 16'h831B;

  minterm_if ifa ();
  minterm_if ifb ();

  assign ifa.fn_f = eval_tt[ifa.fn_i];
  assign ifb.fn_f = eval_tt[ifb.fn_i];

  minterm_scanner #(.SETTLE(0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  minterm_scanner #(.SETTLE(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a(input logic [3:0] l, input logic [3:0] h, input logic [15:0] e);
    ifa.lo = l;
    ifa.hi = h;
    ifa.expected = e;
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
  endtask

  task automatic wait_done_a(input int limit, output int n);
    n = 0;
    while (ifa.done !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
  endtask

  initial begin
    ifa.start = 0; ifa.abort = 0; ifa.lo = 0; ifa.hi = 0; ifa.expected = 0;
    ifb.start = 0; ifb.abort = 0; ifb.lo = 0; ifb.hi = 0; ifb.expected = 0;
    tick();
    tick();
    chk("rst_busy", ifa.busy, 0);
    chk("rst_done", ifa.done, 0);
    chk("rst_map", ifa.map, 0);
    chk("rst_count", ifa.count, 0);
    chk("rst_fn_i", ifa.fn_i, 0);
    rst = 1'b0;

    // full scan, matching expectation
    start_a(4'd0, 4'd15, 16'h831B);
    chk("t1_busy", ifa.busy, 1);
    chk("t1_fn_i0", ifa.fn_i, 0);
    wait_done_a(100, cyc);
    chk("t1_latency", cyc, 16);
    chk("t1_map", ifa.map, 16'h831B);
    chk("t1_count", ifa.count, 7);
    chk("t1_mismatch", ifa.mismatch, 0);
    chk("t1_err", ifa.err, 0);
    chk("t1_fn_i_end", ifa.fn_i, 15);
    tick();
    chk("t1_done_1cyc", ifa.done, 0);
    chk("t1_idle_busy", ifa.busy, 0);

    // full scan, expectation off by bit 0
    start_a(4'd0, 4'd15, 16'h831A);
    wait_done_a(100, cyc);
    chk("t2_latency", cyc, 16);
    chk("t2_map", ifa.map, 16'h831B);
    chk("t2_mismatch", ifa.mismatch, 1);
    chk("t2_count", ifa.count, 7);
    tick();

    // partial range; inputs changed mid-scan must be ignored
    start_a(4'd8, 4'd9, 16'hFFFF);
    ifa.lo = 4'd0; ifa.hi = 4'd15; ifa.expected = 16'h0000;
    wait_done_a(100, cyc);
    chk("t3_latency", cyc, 2);
    chk("t3_map", ifa.map, 16'h0300);
    chk("t3_count", ifa.count, 2);
    chk("t3_mismatch", ifa.mismatch, 0);
    tick();
    chk("t3_hold_map", ifa.map, 16'h0300);

    // range error
    start_a(4'd5, 4'd3, 16'h0000);
    chk("t4_done", ifa.done, 1);
    chk("t4_err", ifa.err, 1);
    chk("t4_busy", ifa.busy, 0);
    chk("t4_map", ifa.map, 16'h0300);
    chk("t4_count", ifa.count, 2);
    tick();
    chk("t4_done_1cyc", ifa.done, 0);
    chk("t4_err_hold", ifa.err, 1);

    // abort after five samples (minterms 0..4)
    start_a(4'd0, 4'd15, 16'h831B);
    repeat (5) tick();
    ifa.abort = 1'b1;
    tick();
    ifa.abort = 1'b0;
    chk("t5_abort_busy", ifa.busy, 0);
    chk("t5_abort_done", ifa.done, 0);
    chk("t5_abort_map", ifa.map, 16'h001B);
    chk("t5_abort_count", ifa.count, 4);
    chk("t5_abort_mism", ifa.mismatch, 0);
    chk("t5_abort_err", ifa.err, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_done", ifa.done, 0);
    end
    chk("t5_map_hold", ifa.map, 16'h001B);

    // start and abort together in IDLE: start wins
    ifa.abort = 1'b1;
    start_a(4'd0, 4'd1, 16'h0003);
    ifa.abort = 1'b0;
    chk("ab_st_busy", ifa.busy, 1);
    wait_done_a(100, cyc);
    chk("ab_st_latency", cyc, 2);
    chk("ab_st_map", ifa.map, 16'h0003);
    chk("ab_st_count", ifa.count, 2);
    tick();

    // reset mid-scan overrides start and abort
    start_a(4'd0, 4'd15, 16'h831B);
    repeat (3) tick();
    rst = 1'b1; ifa.start = 1'b1; ifa.abort = 1'b1;
    tick();
    rst = 1'b0; ifa.start = 1'b0; ifa.abort = 1'b0;
    chk("t5_rst_busy", ifa.busy, 0);
    chk("t5_rst_done", ifa.done, 0);
    chk("t5_rst_err", ifa.err, 0);
    chk("t5_rst_map", ifa.map, 0);
    chk("t5_rst_count", ifa.count, 0);
    chk("t5_rst_mism", ifa.mismatch, 0);
    chk("t5_rst_fn_i", ifa.fn_i, 0);
    start_a(4'd8, 4'd9, 16'h0300);
    chk("post_rst_busy", ifa.busy, 1);
    chk("post_rst_fn_i", ifa.fn_i, 8);
    wait_done_a(100, cyc);
    chk("post_rst_latency", cyc, 2);
    chk("post_rst_map", ifa.map, 16'h0300);
    tick();

    // settle timing on the SETTLE=2 instance, start held high throughout
    ifb.lo = 4'd15; ifb.hi = 4'd15; ifb.expected = 16'h8000; ifb.start = 1'b1;
    tick();
    chk("t6_fn_i_c1", ifb.fn_i, 15);
    chk("t6_busy_c1", ifb.busy, 1);
    tick();
    chk("t6_fn_i_c2", ifb.fn_i, 15);
    chk("t6_done_c2", ifb.done, 0);
    tick();
    chk("t6_fn_i_c3", ifb.fn_i, 15);
    chk("t6_busy_c3", ifb.busy, 1);
    chk("t6_done_c3", ifb.done, 0);
    tick();
    chk("t6_done", ifb.done, 1);
    chk("t6_map", ifb.map, 16'h8000);
    chk("t6_count", ifb.count, 1);
    chk("t6_mismatch", ifb.mismatch, 0);
    chk("t6_busy_done", ifb.busy, 0);
    tick();
    chk("t6_no_rescan_busy", ifb.busy, 0);
    chk("t6_done_1cyc", ifb.done, 0);
    ifb.start = 1'b0;
    tick();
    chk("t6_idle_busy", ifb.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
